// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS general-purpose register file.
// Two combinational read ports feed the ALU operands (rs, rt), and one
// clocked write port takes the writeback value. An optional write-through
// bypass forwards a same-cycle write to a matching read port. A debug port
// always shows stored contents and is never bypassed.
// $0 is hardwired to zero. $28 ($gp) and $29 ($sp) reset to their ABI
// start values, and every other register resets to zero.
module mips_register_file #(
  parameter bit          BYPASS   = 1'b1,
  parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC,
  parameter logic [31:0] GP_RESET = 32'h1000_8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  localparam logic [ADDR_W-1:0] GP_IDX = 5'd28;
  localparam logic [ADDR_W-1:0] SP_IDX = 5'd29;

  // Architectural register storage (flip-flops) and its next state
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // A write is effective only when enabled and not aimed at $0
  logic wr_en;

  // Per-port bypass hits (forced low when bypass is disabled or in reset)
  logic byp_hit1;
  logic byp_hit2;

  // Reset contents of a register: $gp and $sp get their ABI start values
  function automatic logic [DATA_W-1:0] reset_value(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if (idx == GP_IDX) begin
      val = GP_RESET;
    end else if (idx == SP_IDX) begin
      val = SP_RESET;
    end
    return val;
  endfunction

  // Read-port mux. $0 always reads zero, even when a write to it is pending
  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] addr,
    input logic              hit,
    input logic [DATA_W-1:0] fwd_val,
    input logic [DATA_W-1:0] stored_val
  );
    logic [DATA_W-1:0] val;
    if (addr == '0) begin
      val = '0;
    end else if (hit) begin
      val = fwd_val;
    end else begin
      val = stored_val;
    end
    return val;
  endfunction

  assign wr_en = reg_write && (write_reg != '0);

  // Next-state: only the addressed register changes; $0 is pinned to zero
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (write_reg == ADDR_W'(i))) begin
        regs_d[i] = write_data;
      end
    end
    regs_d[0] = '0;
  end

  // Register update: async reset to ABI values, otherwise load next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= reset_value(ADDR_W'(i));
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Bypass detection. Inside reset the pending write is ignored, so the
  // outputs show the reset contents instead of the in-flight data.
  always_comb begin
    byp_hit1 = 1'b0;
    byp_hit2 = 1'b0;
    if (BYPASS && rst_n && wr_en) begin
      byp_hit1 = (write_reg == read_reg1);
      byp_hit2 = (write_reg == read_reg2);
    end
  end

  // Combinational read ports toward the ALU, plus the unbypassed debug port
  always_comb begin
    read_data1 = read_mux(read_reg1, byp_hit1, write_data, regs_q[read_reg1]);
    read_data2 = read_mux(read_reg2, byp_hit2, write_data, regs_q[read_reg2]);
    dbg_data   = read_mux(dbg_addr, 1'b0, write_data, regs_q[dbg_addr]);
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Testbench for mips_register_file. A bypassing instance and a
// non-bypassing instance share every input. Both are checked against an
// array-based model of the architectural register state.
module tb_mips_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  dbg_addr;

  logic [31:0] rd1_b, rd2_b, dbg_b;
  logic [31:0] rd1_n, rd2_n, dbg_n;

  int n_chk;
  int n_pass;

  // Architectural state as seen by software
  logic [31:0] mdl [32];

  mips_register_file #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_b), .read_data2(rd2_b),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  mips_register_file #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_n), .read_data2(rd2_n),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mdl[28] = 32'h1000_8000;
    mdl[29] = 32'h7FFF_EFFC;
  endtask

  // Value a read port must show right now, given the current inputs
  function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
    if (addr == 5'd0) return 32'h0;
    if (byp && rst_n && reg_write && write_reg != 5'd0 && write_reg == addr)
      return write_data;
    return mdl[addr];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rd1_b"}, rd1_b, exp_read(read_reg1, 1'b1));
    chk({tag, ".rd2_b"}, rd2_b, exp_read(read_reg2, 1'b1));
    chk({tag, ".rd1_n"}, rd1_n, exp_read(read_reg1, 1'b0));
    chk({tag, ".rd2_n"}, rd2_n, exp_read(read_reg2, 1'b0));
    chk({tag, ".dbg_b"}, dbg_b, exp_read(dbg_addr, 1'b0));
    chk({tag, ".dbg_n"}, dbg_n, exp_read(dbg_addr, 1'b0));
  endtask

  // Advance through one rising edge and commit the write to the model
  task automatic edge_step();
    @(posedge clk);
    if (rst_n && reg_write && write_reg != 5'd0) mdl[write_reg] = write_data;
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] da);
    reg_write = we; write_reg = wa; write_data = wd;
    read_reg1 = r1; read_reg2 = r2; dbg_addr = da;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    model_reset();

    // Reset state of every register through the debug port and read port 1
    #2;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      read_reg1 = 5'(i);
      #1;
      check_all("rst_state");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Write DEADBEEF to $8, then read it on both ports and debug
    drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd1, 5'd2, 5'd8);
    edge_step();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8);
    #1;
    check_all("wr_rd8");
    chk("wr_rd8.abs", rd1_n, 32'hDEADBEEF);

    // $0 stays zero when written, both before and after the edge
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    #1;
    check_all("zero_pre");
    chk("zero_pre.abs", rd1_b, 32'h0);
    edge_step();
    check_all("zero_post");
    chk("zero_post.abs", rd1_b, 32'h0);

    // Bypass vs no bypass on $9 (holds 1, write 55 pending)
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h1, 5'd0, 5'd0, 5'd9);
    edge_step();
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h55, 5'd0, 5'd9, 5'd9);
    #1;
    check_all("byp_pre");
    chk("byp_pre.b_abs", rd2_b, 32'h55);
    chk("byp_pre.n_abs", rd2_n, 32'h1);
    chk("byp_pre.dbg_abs", dbg_b, 32'h1);
    edge_step();
    check_all("byp_post");
    chk("byp_post.n_abs", rd2_n, 32'h55);
    chk("byp_post.dbg_abs", dbg_n, 32'h55);

    // Both ports bypassing the same register at once
    @(negedge clk);
    drive(1'b1, 5'd17, 32'h1234_5678, 5'd17, 5'd17, 5'd17);
    #1;
    check_all("byp_both");
    edge_step();

    // Asynchronous reset mid-cycle after prior writes, no clock edge needed
    @(negedge clk);
    drive(1'b1, 5'd5, 32'hCAFE_0005, 5'd1, 5'd1, 5'd1);
    edge_step();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5);
    #1;
    check_all("pre_rst5");
    rst_n = 1'b0;
    model_reset();
    #1;
    read_reg1 = 5'd29; #1; chk("async_rst.sp", rd1_b, 32'h7FFF_EFFC);
    read_reg1 = 5'd28; #1; chk("async_rst.gp", rd1_b, 32'h1000_8000);
    read_reg1 = 5'd5;  #1; chk("async_rst.r5", rd1_b, 32'h0);
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset racing a pending write: the write is lost, and the first edge
    // after release accepts a new one
    @(negedge clk);
    drive(1'b1, 5'd10, 32'hA5A5_A5A5, 5'd10, 5'd10, 5'd10);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("race_in_rst");
    edge_step();
    check_all("race_after_edge");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd10, 32'h7, 5'd3, 5'd4, 5'd10);
    #1;
    chk("race_released.dbg", dbg_b, 32'h0);
    check_all("race_released");
    edge_step();
    chk("race_first_wr", dbg_b, 32'h7);
    check_all("race_first_wr");

    // Randomized traffic with occasional mid-cycle async reset pulses
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2) : $urandom),
            $urandom,
            5'($urandom_range(0, 1) == 0 ? $urandom_range(0, 3) : $urandom),
            5'($urandom_range(0, 1) == 0 ? $urandom_range(0, 3) : $urandom),
            5'($urandom));
      #1;
      check_all("rand_pre");
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rand_rst");
        rst_n = 1'b1;
        #1;
      end
      edge_step();
      check_all("rand_post");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Sits directly upstream of the ALU: read ports 1 and 2 drive the ALU rs and rt operands (rt via the ALU-source mux).
- The single write port takes the writeback value: the ALU result or load data.
- Provides an optional write-through bypass for the pipelined datapath, plus a debug read port for testbenches.

Parameters:
- BYPASS, 1: 1 = a same-cycle write to a register being read is forwarded to the read port; 0 = reads return stored contents only.
- SP_RESET, 32'h7FFFEFFC: reset value of $29 ($sp).
- GP_RESET, 32'h10008000: reset value of $28 ($gp).

Ports:
- clk  input  1  clock; all writes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- read_reg1  input  5  read port 1 address (rs field)
- read_reg2  input  5  read port 2 address (rt field)
- read_data1  output  32  read port 1 data, to ALU rs
- read_data2  output  32  read port 2 data, to ALU-source mux / ALU rt
- reg_write  input  1  write enable
- write_reg  input  5  write address (rd, rt or 31 from the upstream mux)
- write_data  input  32  writeback data
- dbg_addr  input  5  debug read address
- dbg_data  output  32  debug read data (stored contents, never bypassed)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Storage: 32 registers, 32 bits each, all flip-flops; no memory inference requirements.
- Reset:
  - rst_n low immediately clears all registers to 0, except $28 = GP_RESET and $29 = SP_RESET.
  - Applies regardless of clk.
  - While rst_n is low, writes are ignored and outputs reflect reset contents.
  - Deassertion takes effect at the next rising clk; the first write is accepted on the first rising edge with rst_n high.
- Write:
  - On rising clk with rst_n high, reg_write = 1 and write_reg != 0: the register at write_reg takes write_data.
  - Write latency 1 cycle: stored value is visible to dbg_data and non-bypassed reads after the edge.
  - reg_write = 0: no change.
  - write_reg = 0: write is discarded; $0 never changes.
- $0: hardwired. Reading address 0 on any port returns 32'h0, including under a bypass match.
- Read:
  - Purely combinational from address to data, zero cycle latency.
  - Outputs update in the same delta as address or content changes.
- Bypass (BYPASS = 1):
  - If reg_write = 1, write_reg != 0 and write_reg == read_regN, then read_dataN = write_data in that cycle, before the edge.
  - Each port is evaluated independently; both ports may bypass simultaneously.
  - With BYPASS = 0, reads return the old value until the edge.
- Simultaneous events:
  - Read and write of the same register in one cycle: governed by BYPASS as above.
  - Both read ports on the same address: identical data.
  - rst_n falling in the same cycle as a write: reset wins; the write is lost.
- No X propagation: every output is defined for every 5-bit address after reset; no uninitialised state is reachable.
- Size: target 120-200 lines of RTL.

Test Plan:
- Reset: hold rst_n = 0 mid-cycle after prior writes -> immediately read_data1 at addr 29 = 32'h7FFFEFFC, addr 28 = 32'h10008000, addr 5 = 0, with no clk edge needed.
- Write/read: write 32'hDEADBEEF to $8, then next cycle read_reg1 = 8, read_reg2 = 8 -> both outputs 32'hDEADBEEF; dbg_addr = 8 gives the same.
- $0 protection: reg_write = 1, write_reg = 0, write_data = 32'hFFFFFFFF, read_reg1 = 0 in the same cycle and the next -> read_data1 = 0 throughout.
- Bypass, BYPASS = 1: $9 holds 32'h1; in one cycle write 32'h55 to $9 with read_reg2 = 9 -> read_data2 = 32'h55 before the edge, dbg_data = 32'h1 until the edge, then 32'h55.
- Bypass off, BYPASS = 0: same stimulus -> read_data2 = 32'h1 before the edge, 32'h55 after.
- Reset vs write race: assert rst_n low during a cycle with a write of 32'hA5A5A5A5 to $10 pending -> $10 = 0 after release; a write of 32'h7 to $10 on the first edge after rst_n high -> $10 = 7.
